// File: rtl/rv_ctrl_pkg.sv
// RV32I opcode/funct constants, control encodings and the decoded control bundle.
package rv_ctrl_pkg;

    localparam int unsigned ILEN   = 32;
    localparam int unsigned REG_AW = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [5:0] {
        EXT_NONE  = 6'b000000,
        EXT_J     = 6'b000001,
        EXT_U     = 6'b000010,
        EXT_B     = 6'b000100,
        EXT_S     = 6'b001000,
        EXT_I     = 6'b010000,
        EXT_SHAMT = 6'b100000
    } ext_op_e;

    typedef enum logic [4:0] {
        ALU_NOP   = 5'b00000,
        ALU_LUI   = 5'b00001,
        ALU_AUIPC = 5'b00010,
        ALU_ADD   = 5'b00011,
        ALU_SUB   = 5'b00100,
        ALU_SLL   = 5'b00101,
        ALU_SRL   = 5'b00110,
        ALU_SRA   = 5'b00111,
        ALU_SLT   = 5'b01000,
        ALU_SLTU  = 5'b01001,
        ALU_OR    = 5'b01101,
        ALU_AND   = 5'b01110,
        ALU_XOR   = 5'b01111
    } alu_op_e;

    typedef enum logic [2:0] {
        NPC_PLUS4  = 3'b000,
        NPC_BRANCH = 3'b001,
        NPC_JUMP   = 3'b010,
        NPC_JALR   = 3'b100
    } npc_op_e;

    typedef enum logic [1:0] {
        WD_ALU = 2'b00,
        WD_MEM = 2'b01,
        WD_PC  = 2'b10
    } wd_sel_e;

    // DMType carries the load/store funct3 directly
    localparam logic [2:0] DM_NONE = 3'b000;

    typedef struct packed {
        logic              reg_write;
        logic              mem_write;
        logic              mem_read;
        logic              alu_src;
        logic              illegal;
        ext_op_e           ext_op;
        alu_op_e           alu_op;
        npc_op_e           npc_op;
        logic [2:0]        dm_type;
        wd_sel_e           wd_sel;
        logic [2:0]        br_funct3;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
    } ctrl_t;

    typedef struct packed {
        ctrl_t ctrl;
        logic  rs1_used;
        logic  rs2_used;
    } dec_t;

endpackage

// File: rtl/rv_decode.sv
// Combinational RV32I decoder: instruction word to control bundle plus source-use flags.
module rv_decode import rv_ctrl_pkg::*; (
    input  logic [ILEN-1:0] instr,
    output dec_t            dec_c
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       legal;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    always_comb begin
        dec_c          = '0;
        legal          = 1'b1;
        dec_c.ctrl.rs1 = instr[19:15];
        dec_c.ctrl.rs2 = instr[24:20];
        dec_c.ctrl.rd  = instr[11:7];

        case (opcode)
            OPC_OP: begin
                dec_c.ctrl.reg_write = 1'b1;
                dec_c.rs1_used       = 1'b1;
                dec_c.rs2_used       = 1'b1;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        F3_ADD_SUB: dec_c.ctrl.alu_op = ALU_ADD;
                        F3_SLL:     dec_c.ctrl.alu_op = ALU_SLL;
                        F3_SLT:     dec_c.ctrl.alu_op = ALU_SLT;
                        F3_SLTU:    dec_c.ctrl.alu_op = ALU_SLTU;
                        F3_XOR:     dec_c.ctrl.alu_op = ALU_XOR;
                        F3_SR:      dec_c.ctrl.alu_op = ALU_SRL;
                        F3_OR:      dec_c.ctrl.alu_op = ALU_OR;
                        default:    dec_c.ctrl.alu_op = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
                    dec_c.ctrl.alu_op = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
                    dec_c.ctrl.alu_op = ALU_SRA;
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                dec_c.ctrl.reg_write = 1'b1;
                dec_c.ctrl.alu_src   = 1'b1;
                dec_c.ctrl.ext_op    = EXT_I;
                dec_c.rs1_used       = 1'b1;
                case (funct3)
                    F3_ADD_SUB: dec_c.ctrl.alu_op = ALU_ADD;
                    F3_SLT:     dec_c.ctrl.alu_op = ALU_SLT;
                    F3_SLTU:    dec_c.ctrl.alu_op = ALU_SLTU;
                    F3_XOR:     dec_c.ctrl.alu_op = ALU_XOR;
                    F3_OR:      dec_c.ctrl.alu_op = ALU_OR;
                    F3_AND:     dec_c.ctrl.alu_op = ALU_AND;
                    F3_SLL: begin
                        dec_c.ctrl.ext_op = EXT_SHAMT;
                        dec_c.ctrl.alu_op = ALU_SLL;
                        legal             = (funct7 == F7_BASE);
                    end
                    default: begin
                        dec_c.ctrl.ext_op = EXT_SHAMT;
                        dec_c.ctrl.alu_op = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        legal             = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    end
                endcase
            end
            OPC_LOAD: begin
                dec_c.ctrl.reg_write = 1'b1;
                dec_c.ctrl.mem_read  = 1'b1;
                dec_c.ctrl.alu_src   = 1'b1;
                dec_c.ctrl.ext_op    = EXT_I;
                dec_c.ctrl.alu_op    = ALU_ADD;
                dec_c.ctrl.wd_sel    = WD_MEM;
                dec_c.ctrl.dm_type   = funct3;
                dec_c.rs1_used       = 1'b1;
                legal = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                        (funct3 == F3_LBU) || (funct3 == F3_LHU);
            end
            OPC_STORE: begin
                dec_c.ctrl.mem_write = 1'b1;
                dec_c.ctrl.alu_src   = 1'b1;
                dec_c.ctrl.ext_op    = EXT_S;
                dec_c.ctrl.alu_op    = ALU_ADD;
                dec_c.ctrl.dm_type   = funct3;
                dec_c.rs1_used       = 1'b1;
                dec_c.rs2_used       = 1'b1;
                legal = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW);
            end
            OPC_BRANCH: begin
                dec_c.ctrl.ext_op    = EXT_B;
                dec_c.ctrl.alu_op    = ALU_SUB;
                dec_c.ctrl.npc_op    = NPC_BRANCH;
                dec_c.ctrl.br_funct3 = funct3;
                dec_c.rs1_used       = 1'b1;
                dec_c.rs2_used       = 1'b1;
                legal = (funct3 == F3_BEQ) || (funct3 == F3_BNE) || (funct3 == F3_BLT) ||
                        (funct3 == F3_BGE) || (funct3 == F3_BLTU) || (funct3 == F3_BGEU);
            end
            OPC_JAL: begin
                dec_c.ctrl.reg_write = 1'b1;
                dec_c.ctrl.ext_op    = EXT_J;
                dec_c.ctrl.alu_op    = ALU_ADD;
                dec_c.ctrl.npc_op    = NPC_JUMP;
                dec_c.ctrl.wd_sel    = WD_PC;
            end
            OPC_JALR: begin
                dec_c.ctrl.reg_write = 1'b1;
                dec_c.ctrl.alu_src   = 1'b1;
                dec_c.ctrl.ext_op    = EXT_I;
                dec_c.ctrl.alu_op    = ALU_ADD;
                dec_c.ctrl.npc_op    = NPC_JALR;
                dec_c.ctrl.wd_sel    = WD_PC;
                dec_c.rs1_used       = 1'b1;
                legal                = (funct3 == 3'b000);
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_c.ctrl.reg_write = 1'b1;
                dec_c.ctrl.alu_src   = 1'b1;
                dec_c.ctrl.ext_op    = EXT_U;
                dec_c.ctrl.alu_op    = (opcode == OPC_LUI) ? ALU_LUI : ALU_AUIPC;
            end
            default: legal = 1'b0;
        endcase

        // Illegal words keep only the raw register fields; no side effects, no redirect
        if (!legal) begin
            dec_c              = '0;
            dec_c.ctrl.illegal = 1'b1;
            dec_c.ctrl.rs1     = instr[19:15];
            dec_c.ctrl.rs2     = instr[24:20];
            dec_c.ctrl.rd      = instr[11:7];
        end
    end

endmodule

// File: rtl/id_ex_ctrl.sv
// ID stage: decode, load-use bubble insertion, flush handling and the ID/EX register.
module id_ex_ctrl import rv_ctrl_pkg::*; #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned RF_AW         = 5,
    parameter int unsigned CNT_W         = 16,
    parameter bit          ENABLE_HAZARD = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    input  logic             ex_valid,
    input  logic             ex_memread,
    input  logic [RF_AW-1:0] ex_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [RF_AW-1:0] out_rs1,
    output logic [RF_AW-1:0] out_rs2,
    output logic [RF_AW-1:0] out_rd,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             MemRead,
    output logic             ALUSrc,
    output logic             illegal,
    output logic [5:0]       EXTOp,
    output logic [4:0]       ALUOp,
    output logic [2:0]       NPCOp,
    output logic [2:0]       DMType,
    output logic [1:0]       WDSel,
    output logic [2:0]       BrFunct3,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    dec_t             dec_c;
    logic             hazard_c;
    logic             out_free_c;
    logic             bubble_c;

    logic             valid_q,     valid_d;
    ctrl_t            ctrl_q,      ctrl_d;
    logic [XLEN-1:0]  pc_q,        pc_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    rv_decode u_decode (
        .instr (in_instr),
        .dec_c (dec_c)
    );

    // Load-use: only sources the instruction really reads can stall it
    assign hazard_c = ENABLE_HAZARD && in_valid && ex_valid && ex_memread && (ex_rd != '0) &&
                      ((dec_c.rs1_used && (RF_AW'(dec_c.ctrl.rs1) == ex_rd)) ||
                       (dec_c.rs2_used && (RF_AW'(dec_c.ctrl.rs2) == ex_rd)));

    assign out_free_c = ~valid_q | out_ready;
    assign bubble_c   = ~flush & hazard_c & out_free_c;
    assign in_ready   = flush | (~hazard_c & out_free_c);

    always_comb begin
        valid_d     = valid_q;
        ctrl_d      = ctrl_q;
        pc_d        = pc_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        // Empty slots are fully zeroed so side-effect bits never leak while invalid
        if (flush || bubble_c) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            pc_d    = '0;
        end else if (in_valid && in_ready) begin
            valid_d = 1'b1;
            ctrl_d  = dec_c.ctrl;
            pc_d    = in_pc;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            pc_d    = '0;
        end

        if (bubble_c && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q     <= 1'b0;
            ctrl_q      <= '0;
            pc_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            ctrl_q      <= ctrl_d;
            pc_q        <= pc_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_pc    = pc_q;
    assign out_rs1   = RF_AW'(ctrl_q.rs1);
    assign out_rs2   = RF_AW'(ctrl_q.rs2);
    assign out_rd    = RF_AW'(ctrl_q.rd);
    assign RegWrite  = ctrl_q.reg_write;
    assign MemWrite  = ctrl_q.mem_write;
    assign MemRead   = ctrl_q.mem_read;
    assign ALUSrc    = ctrl_q.alu_src;
    assign illegal   = ctrl_q.illegal;
    assign EXTOp     = ctrl_q.ext_op;
    assign ALUOp     = ctrl_q.alu_op;
    assign NPCOp     = ctrl_q.npc_op;
    assign DMType    = ctrl_q.dm_type;
    assign WDSel     = ctrl_q.wd_sel;
    assign BrFunct3  = ctrl_q.br_funct3;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_ctrl.sv
// Bench for id_ex_ctrl: decode vector table streamed through a scoreboard, plus hazard/flush/backpressure/reset sequences.
module tb_id_ex_ctrl;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic             in_valid, in_ready, flush, ex_valid, ex_memread;
    logic [31:0]      in_instr, in_pc;
    logic [4:0]       ex_rd;
    logic             out_valid, out_ready;
    logic [31:0]      out_pc;
    logic [4:0]       out_rs1, out_rs2, out_rd;
    logic             RegWrite, MemWrite, MemRead, ALUSrc, illegal;
    logic [5:0]       EXTOp;
    logic [4:0]       ALUOp;
    logic [2:0]       NPCOp, DMType, BrFunct3;
    logic [1:0]       WDSel;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    id_ex_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .ex_valid(ex_valid),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .MemRead(MemRead), .ALUSrc(ALUSrc),
        .illegal(illegal), .EXTOp(EXTOp), .ALUOp(ALUOp), .NPCOp(NPCOp), .DMType(DMType),
        .WDSel(WDSel), .BrFunct3(BrFunct3), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rw, mw, mr, asrc, ill;
        logic [5:0] ext;
        logic [4:0] alu;
        logic [2:0] npc, dm;
        logic [1:0] wd;
        logic [2:0] br;
        logic [4:0] rd;
    } ctl_s;

    typedef struct {
        logic [31:0] instr;
        ctl_s        exp;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1, rs2;
        ctl_s        c;
    } sb_t;

    localparam logic [31:0] ADD_X6_X5_X7 = 32'h00728333;
    localparam logic [31:0] LW_X5        = 32'h0000A283;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] pc_next = 32'h0000_1000;
    sb_t         sb[$];
    vec_t        vecs[18];
    int          exp_stall = 0;
    int          exp_flush = 0;
    ctl_s        c_add6, c_lw5, c_add3;

    function automatic ctl_s mkc(logic rw, logic mw, logic mr, logic asrc, logic ill,
                                 logic [5:0] ext, logic [4:0] alu, logic [2:0] npc,
                                 logic [2:0] dm, logic [1:0] wd, logic [2:0] br, logic [4:0] rd);
        ctl_s c;
        c = '{rw: rw, mw: mw, mr: mr, asrc: asrc, ill: ill, ext: ext, alu: alu,
              npc: npc, dm: dm, wd: wd, br: br, rd: rd};
        return c;
    endfunction

    function automatic ctl_s act_ctl();
        return {RegWrite, MemWrite, MemRead, ALUSrc, illegal, EXTOp, ALUOp,
                NPCOp, DMType, WDSel, BrFunct3, out_rd};
    endfunction

    function automatic logic [127:0] all_outs();
        return {45'd0, out_valid, out_pc, out_rs1, out_rs2, act_ctl(), stall_cnt, flush_cnt};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive an instruction whose decode is expected to reach EX eventually
    task automatic issue(input logic [31:0] ins, input ctl_s c);
        sb_t e;
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc_next;
        e = '{pc: pc_next, rs1: ins[19:15], rs2: ins[24:20], c: c};
        sb.push_back(e);
        pc_next += 32'd4;
    endtask

    task automatic mon();
        sb_t e;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_out", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("sb_out", {out_pc, out_rs1, out_rs2, act_ctl()}, e);
            end
        end
    endtask

    task automatic tick();
        #1;
        mon();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rstn = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
        ex_valid = 1'b0; ex_memread = 1'b0; ex_rd = '0; out_ready = 1'b1;

        c_add6 = mkc(1,0,0,0,0,6'b000000,5'b00011,3'b000,3'b000,2'b00,3'b000,5'd6);
        c_add3 = mkc(1,0,0,0,0,6'b000000,5'b00011,3'b000,3'b000,2'b00,3'b000,5'd3);
        c_lw5  = mkc(1,0,1,1,0,6'b010000,5'b00011,3'b000,3'b010,2'b01,3'b000,5'd5);
        vecs[0]  = '{32'h002081B3, c_add3};
        vecs[1]  = '{32'h402081B3, mkc(1,0,0,0,0,6'b000000,5'b00100,3'b000,3'b000,2'b00,3'b000,5'd3)};
        vecs[2]  = '{32'h0020C1B3, mkc(1,0,0,0,0,6'b000000,5'b01111,3'b000,3'b000,2'b00,3'b000,5'd3)};
        vecs[3]  = '{32'hFFF08293, mkc(1,0,0,1,0,6'b010000,5'b00011,3'b000,3'b000,2'b00,3'b000,5'd5)};
        vecs[4]  = '{32'h4030D293, mkc(1,0,0,1,0,6'b100000,5'b00111,3'b000,3'b000,2'b00,3'b000,5'd5)};
        vecs[5]  = '{32'h0010B293, mkc(1,0,0,1,0,6'b010000,5'b01001,3'b000,3'b000,2'b00,3'b000,5'd5)};
        vecs[6]  = '{LW_X5,        c_lw5};
        vecs[7]  = '{32'h0000C203, mkc(1,0,1,1,0,6'b010000,5'b00011,3'b000,3'b100,2'b01,3'b000,5'd4)};
        vecs[8]  = '{32'h0020A223, mkc(0,1,0,1,0,6'b001000,5'b00011,3'b000,3'b010,2'b00,3'b000,5'd4)};
        vecs[9]  = '{32'h00208463, mkc(0,0,0,0,0,6'b000100,5'b00100,3'b001,3'b000,2'b00,3'b000,5'd8)};
        vecs[10] = '{32'h0020F463, mkc(0,0,0,0,0,6'b000100,5'b00100,3'b001,3'b000,2'b00,3'b111,5'd8)};
        vecs[11] = '{32'h010000EF, mkc(1,0,0,0,0,6'b000001,5'b00011,3'b010,3'b000,2'b10,3'b000,5'd1)};
        vecs[12] = '{32'h000280E7, mkc(1,0,0,1,0,6'b010000,5'b00011,3'b100,3'b000,2'b10,3'b000,5'd1)};
        vecs[13] = '{32'h123453B7, mkc(1,0,0,1,0,6'b000010,5'b00001,3'b000,3'b000,2'b00,3'b000,5'd7)};
        vecs[14] = '{32'h00001417, mkc(1,0,0,1,0,6'b000010,5'b00010,3'b000,3'b000,2'b00,3'b000,5'd8)};
        vecs[15] = '{32'hFFFFFFFF, mkc(0,0,0,0,1,6'b000000,5'b00000,3'b000,3'b000,2'b00,3'b000,5'd31)};
        vecs[16] = '{32'h802081B3, mkc(0,0,0,0,1,6'b000000,5'b00000,3'b000,3'b000,2'b00,3'b000,5'd3)};
        vecs[17] = '{32'h40109293, mkc(0,0,0,0,1,6'b000000,5'b00000,3'b000,3'b000,2'b00,3'b000,5'd5)};

        // Reset state
        #3;
        chk("reset_outputs", all_outs(), 0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("reset_in_ready", in_ready, 1);
        @(posedge clk);
        #2;

        // Back-to-back decode stream
        for (int i = 0; i < 18; i++) begin
            issue(vecs[i].instr, vecs[i].exp);
            #1;
            chk("stream_in_ready", in_ready, 1);
            tick();
            chk("stream_out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drained", out_valid, 0);

        // Load-use: one bubble, then issue once the load leaves EX
        ex_valid = 1'b1; ex_memread = 1'b1; ex_rd = 5'd5;
        issue(ADD_X6_X5_X7, c_add6);
        #1;
        chk("lu_in_ready", in_ready, 0);
        tick();
        exp_stall = 1;
        chk("lu_bubble_valid", out_valid, 0);
        chk("lu_bubble_regwrite", RegWrite, 0);
        chk("lu_stall_cnt", stall_cnt, exp_stall);
        ex_valid = 1'b0;
        #1;
        chk("lu_release_ready", in_ready, 1);
        tick();
        chk("lu_issue_valid", out_valid, 1);
        in_valid = 1'b0;
        tick();

        // Non-hazard cases: rd x0, not a load, unused rs2/rs1 fields
        ex_valid = 1'b1; ex_memread = 1'b1; ex_rd = 5'd0;
        issue(ADD_X6_X5_X7, c_add6);
        #1; chk("rd0_in_ready", in_ready, 1);
        tick();
        ex_memread = 1'b0; ex_rd = 5'd5;
        issue(ADD_X6_X5_X7, c_add6);
        #1; chk("noload_in_ready", in_ready, 1);
        tick();
        ex_memread = 1'b1; ex_rd = 5'd31;
        issue(vecs[3].instr, vecs[3].exp);
        #1; chk("addi_rs2_unused", in_ready, 1);
        tick();
        ex_rd = 5'd8;
        issue(vecs[13].instr, vecs[13].exp);
        #1; chk("lui_rs1_unused", in_ready, 1);
        tick();
        chk("nohaz_stall_cnt", stall_cnt, exp_stall);
        ex_rd = 5'd7;
        issue(ADD_X6_X5_X7, c_add6);
        #1; chk("rs2_haz_in_ready", in_ready, 0);
        tick();
        exp_stall = 2;
        chk("rs2_haz_stall_cnt", stall_cnt, exp_stall);
        ex_valid = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("haz_drained", out_valid, 0);

        // Flush discards the instruction in ID
        in_valid = 1'b1; in_instr = 32'h0020A223; in_pc = 32'hDEAD_0000; flush = 1'b1;
        #1; chk("flush_in_ready", in_ready, 1);
        tick();
        exp_flush = 1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_memwrite", MemWrite, 0);
        chk("flush_cnt_1", flush_cnt, exp_flush);

        // Flush together with hazard: flush wins, no stall counted
        ex_valid = 1'b1; ex_memread = 1'b1; ex_rd = 5'd5;
        in_valid = 1'b1; in_instr = ADD_X6_X5_X7; flush = 1'b1;
        tick();
        exp_flush = 2;
        flush = 1'b0; in_valid = 1'b0; ex_valid = 1'b0;
        chk("flush_haz_stall", stall_cnt, exp_stall);
        chk("flush_haz_flush", flush_cnt, exp_flush);
        chk("flush_haz_valid", out_valid, 0);

        // Backpressure: lw held stable for 3 cycles, next instruction blocked
        issue(LW_X5, c_lw5);
        tick();
        out_ready = 1'b0;
        issue(32'h002081B3, c_add3);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_in_ready", in_ready, 0);
            chk("bp_hold", {out_valid, out_pc, act_ctl()}, {1'b1, sb[0].pc, c_lw5});
            tick();
        end
        chk("bp_memread", MemRead, 1);
        chk("bp_wdsel", WDSel, 2'b01);
        chk("bp_dmtype", DMType, 3'b010);
        out_ready = 1'b1;
        #1; chk("bp_release_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        tick();

        // Flush while EX is not ready still clears the register
        issue(LW_X5, c_lw5);
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        #1;
        chk("fr_valid_before", out_valid, 1);
        flush = 1'b1;
        tick();
        exp_flush = 3;
        flush = 1'b0; out_ready = 1'b1;
        void'(sb.pop_front());
        chk("fr_out_valid", out_valid, 0);
        chk("fr_memread", MemRead, 0);
        chk("fr_flush_cnt", flush_cnt, exp_flush);

        // Counter saturation
        flush = 1'b1;
        for (int k = 0; k < 16; k++) tick();
        flush = 1'b0;
        chk("flush_cnt_sat", flush_cnt, 4'hF);
        ex_valid = 1'b1; ex_memread = 1'b1; ex_rd = 5'd5;
        in_valid = 1'b1; in_instr = ADD_X6_X5_X7;
        for (int k = 0; k < 16; k++) tick();
        chk("stall_cnt_sat", stall_cnt, 4'hF);
        chk("stall_sat_bubble", out_valid, 0);

        // Asynchronous reset between edges
        #3;
        rstn = 1'b0;
        #1;
        chk("async_reset_outputs", all_outs(), 0);
        in_valid = 1'b0; ex_valid = 1'b0; ex_memread = 1'b0;
        #4;
        rstn = 1'b1;
        #1;
        chk("post_reset_in_ready", in_ready, 1);
        @(posedge clk);
        #2;
        chk("post_reset_outputs", all_outs(), 0);
        chk("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
